// File: rtl/alu_cmd_pkg.sv
// Shared encodings for the ALU command sequencer: requester opcodes,
// ALU function codes and the sequencer state enum.
package alu_cmd_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_SHL = 3'd4;
    localparam logic [2:0] OP_SHR = 3'd5;
    localparam logic [2:0] OP_MUL = 3'd6;
    localparam logic [2:0] OP_DIV = 3'd7;

    localparam logic [4:0] F_ADD = 5'b00010;
    localparam logic [4:0] F_SUB = 5'b00011;
    localparam logic [4:0] F_AND = 5'b01000;
    localparam logic [4:0] F_OR  = 5'b01100;
    localparam logic [4:0] F_SHL = 5'b00000;
    localparam logic [4:0] F_SHR = 5'b10000;
    localparam logic [4:0] F_MUL = 5'b00100;
    localparam logic [4:0] F_DIV = 5'b00110;
    localparam logic [4:0] F_NOP = 5'b11111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISS_LO,
        S_ISS_HI,
        S_WAIT,
        S_DONE
    } state_t;

endpackage

// File: rtl/alu_cmd_seq_dec.sv
// Opcode decoder: maps a requester opcode to the ALU function code and
// flags the ops whose high result nibble is meaningless.
module alu_op_dec
    import alu_cmd_pkg::*;
(
    input  logic [2:0] i_op,
    output logic [4:0] o_f,
    output logic       o_hi_zero
);

    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        o_f       = F_NOP;
        o_hi_zero = 1'b0;
        case (i_op)
            OP_ADD: o_f = F_ADD;
            OP_SUB: o_f = F_SUB;
            OP_AND: begin o_f = F_AND; o_hi_zero = 1'b1; end
            OP_OR:  begin o_f = F_OR;  o_hi_zero = 1'b1; end
            OP_SHL: begin o_f = F_SHL; o_hi_zero = 1'b1; end
            OP_SHR: begin o_f = F_SHR; o_hi_zero = 1'b1; end
            OP_MUL: o_f = F_MUL;
            OP_DIV: o_f = F_DIV;
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_cmd_seq.sv
// Command sequencer: issues one opcode to the registered 4-bit ALU twice
// (low then high nibble) and assembles the 8-bit result for the requester.
module alu_cmd_seq
    import alu_cmd_pkg::*;
(
    input  logic       CLK,
    input  logic       CLR,
    input  logic       req,
    input  logic [2:0] op,
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       chain,
    input  logic       keep,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] res,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [4:0] alu_f,
    output logic       alu_v,
    output logic       alu_save,
    output logic       alu_load,
    input  logic [3:0] alu_y
);

    state_t     r_state;
    state_t     w_next;
    logic [2:0] r_op;
    logic [3:0] r_x;
    logic [3:0] r_y;
    logic [3:0] r_lo;
    logic       r_chain;
    logic       r_keep;
    logic [7:0] r_res;
    logic       r_err;

    logic [4:0] w_f;
    logic       w_hi_zero;
    logic       w_accept;
    logic       w_div0;

    alu_op_dec u_dec (
        .i_op      (r_op),
        .o_f       (w_f),
        .o_hi_zero (w_hi_zero)
    );

    assign w_accept = req && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_div0   = (op == OP_DIV) && (y == 4'd0);

    assign busy = (r_state == S_ISS_LO) || (r_state == S_ISS_HI) || (r_state == S_WAIT);
    assign done = (r_state == S_DONE);
    assign res  = r_res;
    assign err  = r_err;

    always_comb begin
        w_next   = r_state;
        alu_f    = F_NOP;
        alu_a    = 4'd0;
        alu_b    = 4'd0;
        alu_v    = 1'b0;
        alu_save = 1'b0;
        alu_load = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept) w_next = w_div0 ? S_DONE : S_ISS_LO;
                else          w_next = S_IDLE;
            end
            S_ISS_LO: begin
                alu_f    = w_f;
                alu_a    = r_x;
                alu_b    = r_y;
                alu_load = r_chain;
                alu_save = r_keep;
                w_next   = S_ISS_HI;
            end
            S_ISS_HI: begin
                alu_f    = w_f;
                alu_a    = r_x;
                alu_b    = r_y;
                alu_v    = 1'b1;
                alu_load = r_chain;
                w_next   = S_WAIT;
            end
            S_WAIT: begin
                alu_a  = r_x;
                alu_b  = r_y;
                w_next = S_DONE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // NOTE: state and data registers use non-blocking assignments only.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // res/err change only at a completion so the previous result stays
    // readable while the next operation is in flight.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_op    <= OP_ADD;
            r_x     <= 4'd0;
            r_y     <= 4'd0;
            r_lo    <= 4'd0;
            r_chain <= 1'b0;
            r_keep  <= 1'b0;
            r_res   <= 8'd0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op    <= op;
                r_x     <= x;
                r_y     <= y;
                r_chain <= chain;
                r_keep  <= keep;
                if (w_div0) begin
                    r_res <= 8'hFF;
                    r_err <= 1'b1;
                end
            end
            if (r_state == S_ISS_HI) r_lo <= alu_y;
            if (r_state == S_WAIT) begin
                r_res <= {(w_hi_zero ? 4'h0 : alu_y), r_lo};
                r_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Self-checking bench for alu_cmd_seq with a behavioural registered ALU
// attached and a scoreboard queue of expected {err, res} completions.
module tb_alu_cmd_seq;
    import alu_cmd_pkg::*;

    logic       CLK = 1'b0;
    logic       CLR;
    logic       req;
    logic [2:0] op;
    logic [3:0] x;
    logic [3:0] y;
    logic       chain;
    logic       keep;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] res;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [4:0] alu_f;
    logic       alu_v;
    logic       alu_save;
    logic       alu_load;
    logic [3:0] alu_y = 4'd0;
    logic [3:0] alu_mem = 4'd0;
    logic [7:0] alu_full;

    int total = 0;
    int bad = 0;
    logic [8:0] exp_q[$];

    typedef struct {
        logic [2:0] op;
        logic [3:0] x;
        logic [3:0] y;
        logic       chain;
        logic       keep;
        logic [7:0] res;
        logic       err;
        int         lat;
    } vec_t;

    vec_t vecs[14];

    always #5 CLK = ~CLK;

    alu_cmd_seq dut (
        .CLK      (CLK),
        .CLR      (CLR),
        .req      (req),
        .op       (op),
        .x        (x),
        .y        (y),
        .chain    (chain),
        .keep     (keep),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .res      (res),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_f    (alu_f),
        .alu_v    (alu_v),
        .alu_save (alu_save),
        .alu_load (alu_load),
        .alu_y    (alu_y)
    );

    // Reference ALU: {high, low} nibble pair for a function code. Logic and
    // shift ops return a non-zero high nibble so the forcing to zero is visible.
    function automatic logic [7:0] alu_calc(input logic [4:0] f, input logic [3:0] a, input logic [3:0] b);
        logic [4:0] d;
        logic [3:0] l;
        case (f)
            F_ADD: begin d = {1'b0, a} + {1'b0, b}; return {3'b000, d}; end
            F_SUB: begin d = {1'b0, a} - {1'b0, b}; return {{4{d[4]}}, d[3:0]}; end
            F_AND: begin l = a & b; return {~l, l}; end
            F_OR:  begin l = a | b; return {~l, l}; end
            F_SHL: begin l = {a[2:0], 1'b0}; return {~l, l}; end
            F_SHR: begin l = {1'b0, a[3:1]}; return {~l, l}; end
            F_MUL: return {4'd0, a} * {4'd0, b};
            F_DIV: begin
                if (b == 4'd0) return 8'hFF;
                return {a % b, a / b};
            end
            default: return 8'h00;
        endcase
    endfunction

    assign alu_full = alu_calc(alu_f, alu_load ? alu_mem : alu_a, alu_b);

    always @(posedge CLK) begin
        alu_y <= alu_v ? alu_full[7:4] : alu_full[3:0];
        if (alu_save) alu_mem <= alu_full[3:0];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard consumer: every done pulse must match the oldest expectation.
    always @(negedge CLK) begin
        if (done === 1'b1) begin
            check("busy_low_in_done", {31'd0, busy}, 32'd0);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected no completion (res=%0h)", res);
            end else begin
                check("res", {24'd0, res}, {24'd0, exp_q[0][7:0]});
                check("err", {31'd0, err}, {31'd0, exp_q[0][8]});
                exp_q.delete(0);
            end
        end
    end

    task automatic issue(input vec_t v, input string name);
        int n;
        @(negedge CLK);
        op = v.op; x = v.x; y = v.y; chain = v.chain; keep = v.keep; req = 1'b1;
        exp_q.push_back({v.err, v.res});
        @(negedge CLK);
        req = 1'b0;
        op = ~v.op; x = ~v.x; y = ~v.y;
        n = 1;
        while (done !== 1'b1 && n < 12) begin
            if (n == 3) begin
                check({name, "_hold_a"}, {28'd0, alu_a}, {28'd0, v.x});
                check({name, "_wait_nop"}, {27'd0, alu_f}, {27'd0, F_NOP});
            end
            @(negedge CLK);
            n++;
        end
        check({name, "_latency"}, n, v.lat);
        if (v.lat == 1) check({name, "_div0_nop"}, {27'd0, alu_f}, {27'd0, F_NOP});
    endtask

    initial begin
        int cnt;
        int dones;
        int last;

        vecs[0]  = '{OP_ADD, 4'hE, 4'h6, 1'b0, 1'b0, 8'h14, 1'b0, 4};
        vecs[1]  = '{OP_SUB, 4'h6, 4'hA, 1'b0, 1'b0, 8'hFC, 1'b0, 4};
        vecs[2]  = '{OP_MUL, 4'hE, 4'h6, 1'b0, 1'b0, 8'h54, 1'b0, 4};
        vecs[3]  = '{OP_DIV, 4'hE, 4'h6, 1'b0, 1'b0, 8'h22, 1'b0, 4};
        vecs[4]  = '{OP_DIV, 4'h5, 4'h0, 1'b0, 1'b0, 8'hFF, 1'b1, 1};
        vecs[5]  = '{OP_ADD, 4'h3, 4'h4, 1'b0, 1'b1, 8'h07, 1'b0, 4};
        vecs[6]  = '{OP_AND, 4'h0, 4'h5, 1'b1, 1'b0, 8'h05, 1'b0, 4};
        vecs[7]  = '{OP_OR,  4'h9, 4'h6, 1'b0, 1'b0, 8'h0F, 1'b0, 4};
        vecs[8]  = '{OP_SHL, 4'h5, 4'h0, 1'b0, 1'b0, 8'h0A, 1'b0, 4};
        vecs[9]  = '{OP_SHR, 4'h9, 4'h0, 1'b0, 1'b0, 8'h04, 1'b0, 4};
        vecs[10] = '{OP_SUB, 4'h9, 4'h3, 1'b0, 1'b0, 8'h06, 1'b0, 4};
        vecs[11] = '{OP_ADD, 4'hF, 4'hF, 1'b0, 1'b0, 8'h1E, 1'b0, 4};
        vecs[12] = '{OP_MUL, 4'hF, 4'hF, 1'b0, 1'b0, 8'hE1, 1'b0, 4};
        vecs[13] = '{OP_DIV, 4'hF, 4'h1, 1'b0, 1'b0, 8'h0F, 1'b0, 4};

        CLR = 1'b1; req = 1'b0; op = OP_ADD; x = 4'd0; y = 4'd0; chain = 1'b0; keep = 1'b0;
        repeat (2) @(negedge CLK);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_res", {24'd0, res}, 32'd0);
        check("rst_alu_f", {27'd0, alu_f}, {27'd0, F_NOP});
        check("rst_ctrl", {20'd0, alu_a, alu_b, alu_v, alu_save, alu_load}, 32'd0);
        CLR = 1'b0;

        for (int i = 0; i < 14; i++) issue(vecs[i], $sformatf("vec%0d", i));

        // req held high: a new operation every 4 cycles, accepted from DONE.
        @(negedge CLK);
        op = OP_ADD; x = 4'h5; y = 4'h6; chain = 1'b0; keep = 1'b0; req = 1'b1;
        repeat (3) exp_q.push_back({1'b0, 8'h0B});
        cnt = 0; dones = 0; last = 0;
        while (dones < 3 && cnt < 40) begin
            @(negedge CLK);
            cnt++;
            if (done === 1'b1) begin
                dones++;
                if (dones > 1) check("b2b_period", cnt - last, 4);
                last = cnt;
                if (dones == 3) req = 1'b0;
            end
        end
        check("b2b_count", dones, 3);

        // A request pulse while busy must be ignored.
        @(negedge CLK);
        op = OP_ADD; x = 4'h1; y = 4'h2; req = 1'b1;
        exp_q.push_back({1'b0, 8'h03});
        @(negedge CLK);
        req = 1'b0;
        @(negedge CLK);
        op = OP_MUL; x = 4'hF; y = 4'hF; req = 1'b1;
        @(negedge CLK);
        req = 1'b0;
        repeat (8) @(negedge CLK);
        check("ignore_idle_busy", {31'd0, busy}, 32'd0);
        check("ignore_res", {24'd0, res}, 32'h03);

        // CLR during ISS_HI aborts: outputs reset at once and no done follows.
        @(negedge CLK);
        op = OP_SUB; x = 4'h2; y = 4'h1; req = 1'b1;
        @(negedge CLK);
        req = 1'b0;
        @(negedge CLK);
        check("abort_in_iss_hi", {31'd0, alu_v}, 32'd1);
        CLR = 1'b1;
        #1;
        check("abort_res", {24'd0, res}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_alu_f", {27'd0, alu_f}, {27'd0, F_NOP});
        @(negedge CLK);
        CLR = 1'b0;
        repeat (6) @(negedge CLK);
        issue('{OP_ADD, 4'h3, 4'h4, 1'b0, 1'b0, 8'h07, 1'b0, 4}, "after_clr");

        repeat (2) @(negedge CLK);
        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_cmd_seq.md
# alu_cmd_seq

Command sequencer that drives the registered 4-bit ALU's control/operand interface on behalf of a requester. It accepts one operation per request handshake, issues the ALU opcode twice (v=0, then v=1), and assembles the two returned nibbles into an 8-bit result: sum with carry, sign-extended difference, product, or {remainder, quotient}. It sits between a requester (controller or testbench) and the ALU. The ALU's own active-low CLR stays outside this block.

## Interface
Parameters: none.
- CLK  in  1  sole clock; all state and the ALU update on posedge
- CLR  in  1  asynchronous, active-high reset
- req  in  1  operation request; sampled only while accepting
- op  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SHL, 5 SHR, 6 MUL, 7 DIV
- x, y  in  4 each  operands; drive ALU a and b
- chain  in  1  use ALU stored memory instead of x (drives alu_load)
- keep  in  1  store low result nibble in ALU memory (drives alu_save)
- busy  out  1  operation in flight
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done; divide by zero
- res  out  8  result; held until the next completion
- alu_a, alu_b  out  4  ALU operands
- alu_f  out  5  ALU function code
- alu_v, alu_save, alu_load  out  1  ALU select, save and load controls
- alu_y  in  4  registered ALU output

## Operation
- States: IDLE, ISS_LO, ISS_HI, WAIT, DONE.
- Acceptance: in IDLE or DONE, `req`=1 at a posedge latches op, x, y, chain and keep, then moves to ISS_LO. Otherwise the request is ignored.
- Opcode-to-`alu_f` map: ADD 00010, SUB 00011, AND 01000, OR 01100, SHL 00000, SHR 10000, MUL 00100, DIV 00110. NOP is 11111; the ALU outputs 0 for NOP.
- ISS_LO:
  - alu_f = mapped code, alu_v=0.
  - alu_load = chain; alu_save = keep.
  - Next state ISS_HI.
- ISS_HI:
  - Same alu_f and alu_load; alu_v=1, alu_save=0.
  - Capture res[3:0] = alu_y.
  - Next state WAIT.
- WAIT:
  - alu_f=NOP, alu_v/alu_save/alu_load=0.
  - Capture res[7:4] = alu_y; AND, OR, SHL and SHR force res[7:4]=0.
  - Next state DONE.
- DONE: done=1 for exactly one cycle. Next state is IDLE, or ISS_LO if req=1.
- Divide by zero: op=DIV with y=0 is not issued. Accepting it goes straight to DONE with res=8'hFF and err=1. err is 0 on every other completion.
- IDLE and DONE drive alu_f=NOP, alu_a/alu_b=0 and all ALU controls 0.
- alu_a/alu_b hold the latched x/y from ISS_LO through WAIT.
- Result formats:
  - ADD: 8-bit sum, {000, carry, sum}.
  - SUB: difference sign-extended by the ALU borrow nibble.
  - MUL: 8-bit product.
  - DIV: {remainder, quotient}.

## Timing
- Request accepted at edge E0 → ISS_LO after E0 → ISS_HI after E1 → WAIT after E2 → DONE after E3.
- done is high during the cycle after E3. Latency is 4 cycles from the accepting edge; the divide-by-zero path takes 1 cycle.
- busy=1 in ISS_LO, ISS_HI and WAIT; 0 in IDLE and DONE. Back-to-back throughput is one operation per 4 cycles.
- The ALU computes y from inputs sampled at the same edge, so the low nibble is valid after E1 and the high nibble after E2. The sequencer samples them at E2 and E3.
- With keep=1, the ALU memory is written at E1 with the low nibble.
- Reset values: state IDLE, res=0, done=0, err=0, busy=0, alu_f=11111, all other outputs 0.
- CLR mid-operation aborts immediately: no done pulse, res cleared.
- req while busy is ignored, not queued.
- Operand changes after acceptance have no effect.

## Structure
- Package alu_cmd_pkg holds:
  - the op encoding constants;
  - the ALU function-code constants, including NOP=11111;
  - the state enum.
- One combinational sub-module, alu_op_dec, maps op to alu_f and the "high nibble forced to zero" flag.
- Everything else is a single FSM plus registers in alu_cmd_seq.

## Test plan
- ADD x=1110, y=0110 → done 4 cycles after acceptance, res=8'h14, err=0.
- SUB x=0110, y=1010 → res=8'hFC; MUL x=1110, y=0110 → res=8'h54.
- DIV x=1110, y=0110 → res=8'h22; DIV y=0 → done 1 cycle after acceptance, res=8'hFF, err=1, alu_f stays 11111.
- Chaining:
  - ADD x=0011, y=0100 with keep=1 → res=8'h07.
  - Then AND y=0101 with chain=1, x=0000 → res=8'h05.
- req held high continuously with ADD operands → done every 4 cycles; busy never high during DONE; req pulse while busy is ignored.
- CLR asserted in ISS_HI → outputs reset asynchronously, no done. A new request after release completes normally.
